// File: rtl/bsg_scatter_gather_stream.sv
// bsg_scatter_gather_stream: single-stage registered gather/scatter lane permuter with
// forward/backward index maps and a valid/yumi output handshake.
module bsg_scatter_gather_stream #(
  parameter int els_p = 4,
  parameter int width_p = 8,
  localparam int lg_els = $clog2(els_p),
  localparam int cnt_w = $clog2(els_p + 1)
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      v_i,
  output logic                      ready_o,
  input  logic                      mode_i,
  input  logic [els_p-1:0]          mask_i,
  input  logic [els_p*width_p-1:0]  data_i,
  output logic                      v_o,
  input  logic                      yumi_i,
  output logic [els_p*width_p-1:0]  data_o,
  output logic [els_p-1:0]          mask_o,
  output logic [cnt_w-1:0]          count_o,
  output logic [els_p*lg_els-1:0]   fwd_o,
  output logic [els_p*lg_els-1:0]   bk_o
);
  logic [width_p-1:0]       w_lane [els_p];
  logic [cnt_w-1:0]         w_pre [els_p];
  logic [cnt_w-1:0]         w_count;
  logic [els_p*lg_els-1:0]  w_fwd;
  logic [els_p*lg_els-1:0]  w_bk;
  logic [els_p*width_p-1:0] w_data;
  logic [els_p-1:0]         w_mask;
  logic                     w_acc;
  logic                     r_v;
  logic [els_p*width_p-1:0] r_data;
  logic [els_p-1:0]         r_mask;
  logic [cnt_w-1:0]         r_count;
  logic [els_p*lg_els-1:0]  r_fwd;
  logic [els_p*lg_els-1:0]  r_bk;
  // w_pre[i] is the number of set mask bits strictly below lane i; it drives both maps.
  always_comb begin
    w_count = '0;
    for (int i = 0; i < els_p; i++) begin
      w_lane[i] = data_i[i*width_p +: width_p];
      w_pre[i]  = w_count;
      w_count   = w_count + cnt_w'(mask_i[i]);
    end
    w_fwd  = '0;
    w_bk   = '0;
    w_data = '0;
    w_mask = '0;
    for (int k = 0; k < els_p; k++) begin
      for (int i = 0; i < els_p; i++)
        if (mask_i[i] && w_pre[i] == cnt_w'(k)) w_fwd[k*lg_els +: lg_els] = lg_els'(i);
      w_bk[k*lg_els +: lg_els] = mask_i[k] ? lg_els'(w_pre[k]) : '0;
      w_mask[k] = mode_i ? mask_i[k] : (cnt_w'(k) < w_count);
      w_data[k*width_p +: width_p] = mode_i
        ? (mask_i[k] ? w_lane[lg_els'(w_pre[k])] : '0)
        : ((cnt_w'(k) < w_count) ? w_lane[w_fwd[k*lg_els +: lg_els]] : '0);
    end
  end
  assign ready_o = ~r_v | yumi_i;
  assign w_acc   = v_i & ready_o;
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_v     <= 1'b0;
      r_data  <= '0;
      r_mask  <= '0;
      r_count <= '0;
      r_fwd   <= '0;
      r_bk    <= '0;
    end else begin
      r_v <= w_acc | (r_v & ~yumi_i);
      if (w_acc) begin
        r_data  <= w_data;
        r_mask  <= w_mask;
        r_count <= w_count;
        r_fwd   <= w_fwd;
        r_bk    <= w_bk;
      end
    end
  end
  assign v_o     = r_v;
  assign data_o  = r_data;
  assign mask_o  = r_mask;
  assign count_o = r_count;
  assign fwd_o   = r_fwd;
  assign bk_o    = r_bk;
endmodule
